// File: rtl/bitblade_pkg.sv
// bitblade_pkg: shared definitions for the BitBlade partial-sum accumulator.
//   - PREC_2B/PREC_4B/PREC_8B : operand precision codes (code 3 decodes as 2b)
//   - acc_state_e             : accumulator FSM states
//   - prec_to_pairs()         : precision code -> number of 2-bit pairs (1/2/4)
package bitblade_pkg;

  localparam logic [1:0] PREC_2B = 2'd0;
  localparam logic [1:0] PREC_4B = 2'd1;
  localparam logic [1:0] PREC_8B = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } acc_state_e;

  // Number of bit-pairs an operand of the given precision splits into.
  function automatic logic [2:0] prec_to_pairs(input logic [1:0] code);
    logic [2:0] pairs;
    case (code)
      PREC_4B: pairs = 3'd2;
      PREC_8B: pairs = 3'd4;
      default: pairs = 3'd1;  // PREC_2B and the reserved code 3
    endcase
    return pairs;
  endfunction

endpackage

// File: rtl/bitblade_bitpair_ctr.sv
// bitblade_bitpair_ctr: nested (i, j) bit-pair position counter.
// i is the inner (input bit-pair) index, j the outer (weight bit-pair) index.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clr_i              synchronous clear (indices 0, limits back to 1x1)
//   load_i, ni_i, nw_i start a new job with NI x NW pairs, indices 0
//   adv_i              step to the next (i, j) position
//   i_o, j_o           current position
//   shift_o            left shift for the current position, 2*(i+j)
//   last_o             current position is the final one of the job
module bitblade_bitpair_ctr
  import bitblade_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [2:0] ni_i,
  input  logic [2:0] nw_i,
  input  logic       adv_i,
  output logic [1:0] i_o,
  output logic [1:0] j_o,
  output logic [3:0] shift_o,
  output logic       last_o
);

  logic [1:0] i_q, i_d;
  logic [1:0] j_q, j_d;
  logic [2:0] ni_q, ni_d;
  logic [2:0] nw_q, nw_d;
  logic       i_last, j_last;

  assign i_last = ({1'b0, i_q} == (ni_q - 3'd1));
  assign j_last = ({1'b0, j_q} == (nw_q - 3'd1));

  always_comb begin
    i_d  = i_q;
    j_d  = j_q;
    ni_d = ni_q;
    nw_d = nw_q;
    if (clr_i) begin
      i_d  = 2'd0;
      j_d  = 2'd0;
      ni_d = 3'd1;
      nw_d = 3'd1;
    end else if (load_i) begin
      i_d  = 2'd0;
      j_d  = 2'd0;
      ni_d = ni_i;
      nw_d = nw_i;
    end else if (adv_i) begin
      if (i_last) begin
        i_d = 2'd0;
        j_d = j_last ? 2'd0 : j_q + 2'd1;
      end else begin
        i_d = i_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_q  <= 2'd0;
      j_q  <= 2'd0;
      ni_q <= 3'd1;
      nw_q <= 3'd1;
    end else begin
      i_q  <= i_d;
      j_q  <= j_d;
      ni_q <= ni_d;
      nw_q <= nw_d;
    end
  end

  assign i_o     = i_q;
  assign j_o     = j_q;
  // 2*i + 2*j, max 12
  assign shift_o = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
  assign last_o  = i_last && j_last;

endmodule

// File: rtl/bitblade_psum_acc.sv
// bitblade_psum_acc: bit-pair shift-accumulator behind the BitBlade PE array.
// Each accepted partial sum is sign-extended, shifted by 2*(i+j) and added to
// an ACC_W+8 bit accumulator; after NI*NW beats the result is presented on
// OUT_DATA until the consumer takes it.
// Optional feature macro: BITBLADE_ACC_SAT_EN (saturate instead of wrap).
// Handshake: a transfer happens on a rising CLK edge where valid and ready are
// both high; a producer holding valid keeps its data stable until then, and
// ready never depends combinationally on valid.
// Ports:
//   CLK, RST              clock, asynchronous active-low reset
//   FLUSH                 synchronous abort to IDLE
//   CFG_PI, CFG_PW        input / weight precision codes, latched on START
//   START                 begin a job (IDLE, or OUT during the handshake)
//   IN_VALID/IN_PSUM/IN_READY   partial-sum input stream
//   OUT_VALID/OUT_DATA/OUT_READY result output (registered)
//   BUSY                  FSM not in IDLE
//   DBG_STATE, DBG_POS    FSM state and current {j, i} bit-pair position
module bitblade_psum_acc
  import bitblade_pkg::*;
#(
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic [1:0]        CFG_PI,
  input  logic [1:0]        CFG_PW,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [PSUM_W-1:0] IN_PSUM,
  output logic              IN_READY,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ACC_W-1:0]  OUT_DATA,
  output logic              BUSY,
  output logic [1:0]        DBG_STATE,
  output logic [3:0]        DBG_POS
);

  localparam int IW = ACC_W + 8;

  acc_state_e       state_q;
  logic [IW-1:0]    acc_q;
  logic [ACC_W-1:0] out_data_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [IW-1:0]    psum_ext;
  logic [IW-1:0]    acc_nxt;
  logic [ACC_W-1:0] out_nxt;
  logic             start_ok;
  logic             beat;
  logic [1:0]       ctr_i, ctr_j;
  logic [3:0]       ctr_shift;
  logic             ctr_last;

  // A new job may begin from IDLE or in the same cycle the result is taken.
  assign start_ok = START && !FLUSH &&
                    ((state_q == ST_IDLE) || ((state_q == ST_OUT) && OUT_READY));
  assign beat     = (state_q == ST_ACC) && IN_VALID && !FLUSH;

  bitblade_bitpair_ctr u_ctr (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .clr_i   (FLUSH),
    .load_i  (start_ok),
    .ni_i    (prec_to_pairs(CFG_PI)),
    .nw_i    (prec_to_pairs(CFG_PW)),
    .adv_i   (beat),
    .i_o     (ctr_i),
    .j_o     (ctr_j),
    .shift_o (ctr_shift),
    .last_o  (ctr_last)
  );

  assign psum_ext = {{(IW-PSUM_W){IN_PSUM[PSUM_W-1]}}, IN_PSUM};
  assign acc_nxt  = acc_q + (psum_ext << ctr_shift);

  // Result as it will appear on OUT_DATA once the final beat lands.
  always_comb begin
    out_nxt = acc_nxt[ACC_W-1:0];
`ifdef BITBLADE_ACC_SAT_EN
    // Fits in ACC_W signed bits only if all guard bits match the sign bit.
    if (acc_nxt[IW-1:ACC_W-1] != {(IW-ACC_W+1){acc_nxt[IW-1]}}) begin
      out_nxt = acc_nxt[IW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (FLUSH) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_ACC: begin
          if (IN_VALID) begin
            acc_q <= acc_nxt;
            if (ctr_last) begin
              state_q     <= ST_OUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= out_nxt;
            end
          end
        end
        ST_OUT: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            if (START) begin
              state_q    <= ST_ACC;
              acc_q      <= '0;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign BUSY      = busy_q;
  assign DBG_STATE = state_q;
  assign DBG_POS   = {ctr_j, ctr_i};

endmodule

// File: tb/tb_bitblade_psum_acc.sv
// Testbench for bitblade_psum_acc. Two instances share all inputs: one with
// ACC_W=32 and one with ACC_W=16 (exercises wrap/saturation of the result).
// Expected results come from an exact-integer model of the dot product.
module tb_bitblade_psum_acc;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FLUSH = 1'b0;
  logic [1:0]  CFG_PI = 2'd0;
  logic [1:0]  CFG_PW = 2'd0;
  logic        START = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [15:0] IN_PSUM = 16'd0;
  logic        OUT_READY = 1'b0;

  logic        in_ready_a, out_valid_a, busy_a;
  logic [31:0] out_data_a;
  logic [1:0]  dbg_state_a;
  logic [3:0]  dbg_pos_a;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [15:0] out_data_b;
  logic [1:0]  dbg_state_b;
  logic [3:0]  dbg_pos_b;

  bitblade_psum_acc #(.PSUM_W(16), .ACC_W(32)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .CFG_PI(CFG_PI), .CFG_PW(CFG_PW),
    .START(START), .IN_VALID(IN_VALID), .IN_PSUM(IN_PSUM), .IN_READY(in_ready_a),
    .OUT_VALID(out_valid_a), .OUT_READY(OUT_READY), .OUT_DATA(out_data_a),
    .BUSY(busy_a), .DBG_STATE(dbg_state_a), .DBG_POS(dbg_pos_a)
  );

  bitblade_psum_acc #(.PSUM_W(16), .ACC_W(16)) dut16 (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .CFG_PI(CFG_PI), .CFG_PW(CFG_PW),
    .START(START), .IN_VALID(IN_VALID), .IN_PSUM(IN_PSUM), .IN_READY(in_ready_b),
    .OUT_VALID(out_valid_b), .OUT_READY(OUT_READY), .OUT_DATA(out_data_b),
    .BUSY(busy_b), .DBG_STATE(dbg_state_b), .DBG_POS(dbg_pos_b)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [15:0] exp16_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  // behavioural model of the job in progress
  int          ni_m = 1, nw_m = 1, k_m = 0;
  longint      sum_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pairs(input int code);
    if (code == 1) return 2;
    if (code == 2) return 4;
    return 1;
  endfunction

  // Exact dot product -> OUT_DATA for a result width w (internal width w+8).
  function automatic logic [31:0] exp_val(input longint exact, input int w);
    longint m, r;
`ifdef BITBLADE_ACC_SAT_EN
    longint hi, lo;
`endif
    m = longint'(1) << (w + 8);
    r = exact % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
`ifdef BITBLADE_ACC_SAT_EN
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
`endif
    return 32'(r & ((longint'(1) << w) - 1));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RST && out_valid_a && OUT_READY) begin
      if (exp_q.size() == 0) check("unexpected_out32", out_data_a, 32'hDEADBEEF ^ out_data_a ^ 32'h1);
      else check("out_data32", out_data_a, exp_q.pop_front());
    end
    if (RST && out_valid_b && OUT_READY) begin
      if (exp16_q.size() == 0) check("unexpected_out16", {16'd0, out_data_b}, 32'h0001_0000);
      else check("out_data16", {16'd0, out_data_b}, {16'd0, exp16_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_set(input int pi, input int pw);
    ni_m  = pairs(pi);
    nw_m  = pairs(pw);
    k_m   = 0;
    sum_m = 0;
  endtask

  task automatic begin_job(input int pi, input int pw);
    START  = 1'b1;
    CFG_PI = 2'(pi);
    CFG_PW = 2'(pw);
    tick();
    START  = 1'b0;
    CFG_PI = 2'($urandom_range(0, 3));
    CFG_PW = 2'($urandom_range(0, 3));
    model_set(pi, pw);
    check("start_in_ready", {31'd0, in_ready_a & in_ready_b}, 32'd1);
    check("start_busy", {31'd0, busy_a & busy_b}, 32'd1);
  endtask

  task automatic beat(input logic [15:0] v, input int gap);
    int i, j;
    IN_VALID = 1'b0;
    repeat (gap) tick();
    check("beat_in_ready", {31'd0, in_ready_a & in_ready_b}, 32'd1);
    IN_VALID = 1'b1;
    IN_PSUM  = v;
    i = k_m % ni_m;
    j = k_m / ni_m;
    sum_m += longint'($signed(v)) * (longint'(1) << (2 * (i + j)));
    k_m++;
    tick();
    IN_VALID = 1'b0;
    IN_PSUM  = 16'($urandom);
    if (k_m == ni_m * nw_m) begin
      exp_q.push_back(exp_val(sum_m, 32));
      exp16_q.push_back(16'(exp_val(sum_m, 16)));
      check("last_out_valid", {30'd0, out_valid_a, out_valid_b}, 32'd3);
      check("last_in_ready", {30'd0, in_ready_a, in_ready_b}, 32'd0);
    end else begin
      check("mid_out_valid", {30'd0, out_valid_a, out_valid_b}, 32'd0);
    end
  endtask

  task automatic feed_random(input int max_gap);
    logic [15:0] v;
    for (int n = 0; n < ni_m * nw_m; n++) begin
      case ($urandom_range(0, 3))
        0: v = 16'h7FFF;
        1: v = 16'h8000;
        default: v = 16'($urandom);
      endcase
      beat(v, $urandom_range(0, max_gap));
    end
  endtask

  // Hold the result for 'hold' cycles (with ignored noise), then take it.
  task automatic drain(input int hold, input bit chain, input int pi, input int pw);
    for (int h = 0; h < hold; h++) begin
      OUT_READY = 1'b0;
      check("hold_out_valid", {30'd0, out_valid_a, out_valid_b}, 32'd3);
      check("hold_in_ready", {30'd0, in_ready_a, in_ready_b}, 32'd0);
      if (exp_q.size() > 0) check("hold_data32", out_data_a, exp_q[0]);
      if (exp16_q.size() > 0) check("hold_data16", {16'd0, out_data_b}, {16'd0, exp16_q[0]});
      START    = 1'($urandom_range(0, 1));
      IN_VALID = 1'($urandom_range(0, 1));
      IN_PSUM  = 16'($urandom);
      tick();
    end
    IN_VALID  = 1'b0;
    START     = chain;
    CFG_PI    = 2'(pi);
    CFG_PW    = 2'(pw);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    START     = 1'b0;
    if (chain) begin
      model_set(pi, pw);
      check("chain_in_ready", {30'd0, in_ready_a, in_ready_b}, 32'd3);
      check("chain_busy", {30'd0, busy_a, busy_b}, 32'd3);
    end else begin
      check("done_busy", {30'd0, busy_a, busy_b}, 32'd0);
    end
    check("after_hs_out_valid", {30'd0, out_valid_a, out_valid_b}, 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {in_ready_a, in_ready_b, out_valid_a, out_valid_b, busy_a, busy_b, 26'd0}, 32'd0);
    check({name, "_data32"}, out_data_a, 32'd0);
    check({name, "_data16"}, {16'd0, out_data_b}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit chain;
    int pi, pw;

    // reset
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;
    tick();
    check_all_zero("post_reset");

    // 2b/2b single beat of -3
    begin_job(0, 0);
    beat(16'hFFFD, 0);
    check("t1_data32_direct", out_data_a, 32'hFFFF_FFFD);
    drain(0, 1'b0, 0, 0);

    // 4b/4b four ones -> 25, held 5 cycles, then chained start
    begin_job(1, 1);
    for (int n = 0; n < 4; n++) beat(16'd1, 0);
    check("t2_data32_direct", out_data_a, 32'd25);
    drain(5, 1'b1, 0, 0);
    beat(16'hFFFD, 1);
    drain(1, 1'b0, 0, 0);

    // 8b/8b flushed after 3 beats; FLUSH beats START in IDLE
    begin_job(2, 2);
    for (int n = 0; n < 3; n++) beat(16'($urandom), $urandom_range(0, 1));
    FLUSH = 1'b1;
    tick();
    check("flush_busy", {30'd0, busy_a, busy_b}, 32'd0);
    check("flush_in_ready", {30'd0, in_ready_a, in_ready_b}, 32'd0);
    START = 1'b1;
    tick();
    FLUSH = 1'b0;
    START = 1'b0;
    check("flush_beats_start", {30'd0, busy_a, busy_b}, 32'd0);
    begin_job(0, 0);
    beat(16'd7, 0);
    drain(0, 1'b0, 0, 0);

    // flush while a result is waiting
    begin_job(1, 0);
    beat(16'd5, 0);
    beat(16'd9, 0);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flush_out_valid", {30'd0, out_valid_a, out_valid_b}, 32'd0);
    void'(exp_q.pop_back());
    void'(exp16_q.pop_back());

    // asynchronous reset mid-job
    begin_job(1, 1);
    beat(16'd100, 2);
    beat(16'd200, 1);
    #2;
    RST = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge CLK);
    RST = 1'b1;
    tick();
    begin_job(1, 0);
    beat(16'd2, 1);
    beat(16'd3, 0);
    check("t5_data32_direct", out_data_a, 32'd14);
    drain(0, 1'b0, 0, 0);

    // 8b/8b, 16 beats of 0x7FFF at full throughput
    begin_job(2, 2);
    for (int n = 0; n < 16; n++) beat(16'h7FFF, 0);
    check("t6_data32_direct", out_data_a, 32'd236741575);
    drain(2, 1'b0, 0, 0);

    // randomized jobs with gaps, stalls and back-to-back starts
    chain = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (!chain) begin
        pi = $urandom_range(0, 3);
        pw = $urandom_range(0, 3);
        begin_job(pi, pw);
      end
      feed_random(2);
      chain = 1'($urandom_range(0, 1));
      drain($urandom_range(0, 3), chain, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    if (chain) begin
      feed_random(0);
      drain(0, 1'b0, 0, 0);
    end

    repeat (2) tick();
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("exp16_q_empty", exp16_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bitblade_psum_acc.md
# bitblade_psum_acc

Bit-pair shift-accumulator that sits directly downstream of the BitBlade 2-bit reconfigurable multiplier/adder-tree array. It consumes one signed partial sum per (input bit-pair, weight bit-pair) iteration, shifts each by 2·(i+j), and accumulates them into a full-precision dot-product result. It supports 2/4/8-bit input and weight precisions and a synchronous flush. The result is returned through a valid/ready handshake to the output/requantisation stage.

## Interface
Parameters:
- PSUM_W, 16, width of signed partial sum from the PE array
- ACC_W, 32, width of signed output result

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- FLUSH  in  1  synchronous clear to IDLE, acc := 0
- CFG_PI  in  2  input precision code: 0=2b, 1=4b, 2=8b, 3 treated as 2b
- CFG_PW  in  2  weight precision code, same encoding
- START  in  1  begin job, latches CFG_PI/CFG_PW
- IN_VALID  in  1  IN_PSUM valid
- IN_PSUM  in  PSUM_W  signed partial sum for current bit-pair (i,j)
- IN_READY  out  1  block accepts IN_PSUM
- OUT_VALID  out  1  OUT_DATA valid
- OUT_READY  in  1  consumer accepts OUT_DATA
- OUT_DATA  out  ACC_W  signed accumulated result
- BUSY  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACC, OUT.
- IDLE: START → latch NI=PI/2, NW=PW/2 (1/2/4), clear acc, clear counters i=j=0, go ACC.
- ACC: IN_READY=1. Each beat (IN_VALID&IN_READY): acc += sext(IN_PSUM) << 2·(i+j). Order: i inner (0..NI-1), j outer (0..NW-1). Beats per job = NI·NW (1, 2, 4, 8, 16). Last beat → OUT.
- OUT: OUT_VALID=1, OUT_DATA=acc, held stable until OUT_READY. Handshake → IDLE, or directly → ACC if START is high the same cycle (new config latched, acc cleared).
- START outside IDLE/OUT-handshake is ignored. IN_VALID outside ACC is ignored (IN_READY=0).
- Signedness is resolved upstream: IN_PSUM is always treated as two's-complement and sign-extended.
- Default arithmetic wraps modulo 2^ACC_W. The internal accumulator is ACC_W+8 bits; OUT_DATA is its low ACC_W bits.
- FLUSH (any state) → IDLE, acc=0, counters=0, OUT_VALID=0 next edge. If FLUSH and START are both high, FLUSH wins.
- RST low (any time, including mid-job) → IDLE, acc=0, counters=0 immediately.

## Timing
- Reset values: IN_READY=0, OUT_VALID=0, OUT_DATA=0, BUSY=0.
- START edge → IN_READY=1 on the following cycle.
- Full throughput: one beat per cycle in ACC, no bubbles.
- Latency: last beat accepted at edge N → OUT_VALID=1 after edge N (one register stage).
- Minimum job period is NI·NW+1 cycles with back-to-back START at the OUT handshake.
- OUT_DATA and OUT_VALID are registered outputs, with no combinational path from OUT_READY.

## Configuration
- BITBLADE_ACC_SAT_EN defined: OUT_DATA is the internal accumulator clamped to the signed ACC_W range, [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- BITBLADE_ACC_SAT_EN undefined: OUT_DATA is the low ACC_W bits of the internal accumulator (wrap).

## Structure
- Shared package bitblade_pkg holds:
  - precision-code localparams (PREC_2B/4B/8B)
  - FSM state enum
  - function mapping a precision code to a bit-pair count
- One sub-module, bitblade_bitpair_ctr:
  - nested i/j counter with load(NI,NW), advance, and clear
  - outputs i, j, shift amount 2·(i+j), and last flag.
- The accumulator register, FSM and saturation stay in the top module.

## Test plan
1. 2b/2b, START, one beat IN_PSUM=-3 → OUT_VALID next cycle, OUT_DATA=0xFFFFFFFD; handshake → BUSY=0.
2. 4b/4b, four beats of value 1 in order (i,j)=(0,0),(1,0),(0,1),(1,1) → OUT_DATA=1+4+4+16=25.
3. Hold OUT_READY low 5 cycles → OUT_VALID and OUT_DATA stable, IN_READY=0, START ignored. Then OUT_READY+START same cycle → new job starts with acc=0.
4. 8b/8b, FLUSH after 3 of 16 beats → IDLE next edge, acc=0. A following 2b/2b job with IN_PSUM=7 → OUT_DATA=7.
5. RST low mid-ACC with IN_VALID gaps → all outputs 0 immediately. After release, a 4b/2b job with beats 2,3 → 2+3·4=14.
6. ACC_W=16, 8b/8b, 16 beats of 0x7FFF:
   - exact sum 236,741,575
   - with BITBLADE_ACC_SAT_EN → OUT_DATA=0x7FFF
   - without → OUT_DATA=0x63C7
